// File: rtl/sqb_pkg.sv
// sqb_pkg: shared types and helpers for stack_queue_buffer.
//   sqb_mode_e : run-time buffer behaviour (LIFO stack or FIFO queue).
//   next_ptr   : circular pointer increment for any depth, including depths
//                that are not powers of two.
package sqb_pkg;

  typedef enum logic {
    MODE_LIFO = 1'b0,
    MODE_FIFO = 1'b1
  } sqb_mode_e;

  // Advance a ring pointer, wrapping from depth-1 back to 0.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sqb_occupancy_counter.sv
// sqb_occupancy_counter: registered occupancy count plus its status flags.
// The flags are computed from the next count and registered together with
// it, so none of them lags the count.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   inc, dec          accepted push / accepted pop strobes
//   count             occupancy, 0..DEPTH
//   full, empty       count == DEPTH / count == 0
//   almost_full       count >= AF_LEVEL
module sqb_occupancy_counter #(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           inc,
  input  logic                           dec,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic             AF_RST    = (AF_LEVEL == 0);

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q, af_q;

  always_comb begin
    count_d = count_q;
    case ({inc, dec})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= AF_RST;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_CNT);
      empty_q <= (count_d == '0);
      af_q    <= (count_d >= AF_CNT);
    end
  end

  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;

endmodule

// File: rtl/stack_queue_buffer.sv
// stack_queue_buffer: single-clock storage buffer usable as a LIFO stack or
// a FIFO queue, selected at run time while the buffer is idle and empty.
// Optional feature macro: SQB_ERR_FLAGS_EN enables sticky overflow/underflow
// flags; without it both flags are tied low and err_clr is ignored.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   mode            0 = LIFO, 1 = FIFO; sampled only while empty and idle
//   push, push_data level-sensitive write request and its data
//   pop             level-sensitive read request
//   pop_data        registered read data, holds between pops
//   pop_valid       one-cycle pulse after each accepted pop
//   count           occupancy 0..DEPTH
//   full, empty, almost_full   status flags derived from count
//   overflow, underflow        sticky error flags
//   err_clr         synchronous clear of the error flags
//
// Handshake: push/pop are requests held by the producer/consumer. A pop is
// accepted when the buffer is not empty; a push is accepted when the buffer
// is not full, or when it is full but a pop is accepted in the same cycle.
// Exactly one entry moves per accepted request per cycle; a rejected request
// changes nothing and must simply be held until accepted.
module stack_queue_buffer
  import sqb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            pop_data,
  output logic                         pop_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         err_clr
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic              push_acc, pop_acc, idle;
  sqb_mode_e         mode_q, mode_d;
  logic [CNT_W-1:0]  sp_q, sp_d, sp_m1;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  lifo_top, lifo_wr, rd_idx, wr_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pop_data_q;
  logic              pop_valid_q;

  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);
  // Mode is only re-sampled when nothing is stored and nothing is arriving,
  // so a mode change can never reinterpret existing contents.
  assign idle     = empty & ~push;

  sqb_occupancy_counter #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) u_occupancy (
    .clk         (clk),
    .reset       (reset),
    .inc         (push_acc),
    .dec         (pop_acc),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  // LIFO addressing: the top entry lives at sp-1. A combined push+pop
  // replaces the top in place, so the write goes to sp-1 instead of sp.
  assign sp_m1    = sp_q - CNT_W'(1);
  assign lifo_top = PTR_W'(sp_m1);
  assign lifo_wr  = (push_acc & pop_acc) ? lifo_top : PTR_W'(sp_q);
  assign rd_idx   = (mode_q == MODE_FIFO) ? rd_ptr_q : lifo_top;
  assign wr_idx   = (mode_q == MODE_FIFO) ? wr_ptr_q : lifo_wr;

  always_comb begin
    mode_d   = mode_q;
    sp_d     = sp_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (idle) begin
      mode_d   = sqb_mode_e'(mode);
      sp_d     = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (mode_q == MODE_LIFO) begin
      if (push_acc & ~pop_acc)      sp_d = sp_q + CNT_W'(1);
      else if (pop_acc & ~push_acc) sp_d = sp_m1;
    end else begin
      if (push_acc) wr_ptr_d = PTR_W'(next_ptr(32'(wr_ptr_q), DEPTH));
      if (pop_acc)  rd_ptr_d = PTR_W'(next_ptr(32'(rd_ptr_q), DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= MODE_LIFO;
      sp_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      sp_q        <= sp_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_valid_q <= pop_acc;
      if (pop_acc) pop_data_q <= mem[rd_idx];
    end
  end

  // Storage is deliberately not reset; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_idx] <= push_data;
  end

  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;

`ifdef SQB_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // err_clr wins over a new error in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (err_clr) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push & ~push_acc) overflow_q  <= 1'b1;
      if (pop & ~pop_acc)   underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_stack_queue_buffer.sv
// tb_stack_queue_buffer: drives two buffer instances (DEPTH=8/AF_LEVEL=6 and
// DEPTH=5) one at a time against a queue-based reference model; popped data
// is scoreboarded through exp_q.
module tb_stack_queue_buffer;

`ifdef SQB_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       sel;
  logic       mode, push, pop, err_clr;
  logic [7:0] push_data;

  logic [7:0] a_pop_data, b_pop_data;
  logic       a_pop_valid, b_pop_valid;
  logic [3:0] a_count;
  logic [2:0] b_count;
  logic       a_full, a_empty, a_af, a_ovf, a_unf;
  logic       b_full, b_empty, b_af, b_ovf, b_unf;

  stack_queue_buffer #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6)) u_dut_a (
    .clk(clk), .reset(reset), .mode(mode), .push(push & ~sel), .push_data(push_data),
    .pop(pop & ~sel), .pop_data(a_pop_data), .pop_valid(a_pop_valid), .count(a_count),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .overflow(a_ovf),
    .underflow(a_unf), .err_clr(err_clr)
  );

  stack_queue_buffer #(.DATA_W(8), .DEPTH(5)) u_dut_b (
    .clk(clk), .reset(reset), .mode(mode), .push(push & sel), .push_data(push_data),
    .pop(pop & sel), .pop_data(b_pop_data), .pop_valid(b_pop_valid), .count(b_count),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .overflow(b_ovf),
    .underflow(b_unf), .err_clr(err_clr)
  );

  logic [7:0] o_pop_data;
  logic [3:0] o_count;
  logic       o_pop_valid, o_full, o_empty, o_af, o_ovf, o_unf;

  always_comb begin
    o_pop_data  = sel ? b_pop_data  : a_pop_data;
    o_pop_valid = sel ? b_pop_valid : a_pop_valid;
    o_count     = sel ? {1'b0, b_count} : a_count;
    o_full      = sel ? b_full  : a_full;
    o_empty     = sel ? b_empty : a_empty;
    o_af        = sel ? b_af    : a_af;
    o_ovf       = sel ? b_ovf   : a_ovf;
    o_unf       = sel ? b_unf   : a_unf;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] mq[$];
  logic       m_mode, m_valid, m_ovf, m_unf;
  logic [7:0] m_pdata;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_mode  = 1'b0;
    m_valid = 1'b0;
    m_pdata = 8'h00;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_count",     32'(o_count), 32'd0);
    check("rst_empty",     32'(o_empty), 32'd1);
    check("rst_full",      32'(o_full), 32'd0);
    check("rst_af",        32'(o_af), 32'd0);
    check("rst_pop_valid", 32'(o_pop_valid), 32'd0);
    check("rst_pop_data",  32'(o_pop_data), 32'd0);
    check("rst_overflow",  32'(o_ovf), 32'd0);
    check("rst_underflow", 32'(o_unf), 32'd0);
  endtask

  task automatic compare_outputs();
    int af_lvl;
    af_lvl = sel ? 4 : 6;
    check("pop_valid", 32'(o_pop_valid), 32'(m_valid));
    if (o_pop_valid) begin
      if (exp_q.size() == 0) check("sb_unexpected_pop", 32'd1, 32'd0);
      else check("pop_data", 32'(o_pop_data), 32'(exp_q.pop_front()));
    end
    check("pop_data_hold", 32'(o_pop_data), 32'(m_pdata));
    check("count",     32'(o_count), 32'(mq.size()));
    check("full",      32'(o_full),  32'(mq.size() == (sel ? 5 : 8)));
    check("empty",     32'(o_empty), 32'(mq.size() == 0));
    check("af",        32'(o_af),    32'(mq.size() >= af_lvl));
    check("overflow",  32'(o_ovf),   32'(m_ovf));
    check("underflow", 32'(o_unf),   32'(m_unf));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic p, input logic [7:0] d, input logic q,
                       input logic m, input logic ec);
    int         depth;
    logic       pacc, qacc, is_idle;
    logic [7:0] v;
    depth = sel ? 5 : 8;
    @(negedge clk);
    push = p; push_data = d; pop = q; mode = m; err_clr = ec;
    is_idle = (mq.size() == 0) && !p;
    qacc = q && (mq.size() > 0);
    pacc = p && ((mq.size() < depth) || qacc);
    if (ERR_EN) begin
      if (ec) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        if (p && !pacc) m_ovf = 1'b1;
        if (q && !qacc) m_unf = 1'b1;
      end
    end
    if (qacc) begin
      v = m_mode ? mq.pop_front() : mq.pop_back();
      exp_q.push_back(v);
      m_pdata = v;
    end
    if (pacc) mq.push_back(d);
    if (is_idle) m_mode = m;
    m_valid = qacc;
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; mode = 1'b0;
    push_data = 8'h00;
    @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic random_traffic(input int n, input logic allow_mode_change);
    for (int i = 0; i < n; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)),
            allow_mode_change ? 1'($urandom_range(0, 1)) : m_mode,
            1'($urandom_range(0, 9) == 0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sel = 1'b0; reset = 1'b0; mode = 1'b0; push = 1'b0; pop = 1'b0;
    err_clr = 1'b0; push_data = 8'h00;
    model_clear();
    do_reset();

    // LIFO fill: 0x11..0x18, then a 9th push that must be rejected.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // LIFO full with simultaneous push+pop: top 0x18 out, 0x55 replaces it.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Pop while empty, then clear the sticky flag.
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Push+pop while empty: only the push is accepted.
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Mode capture: mode=1 while occupied keeps LIFO; one idle cycle flips to FIFO.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h31 + i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h41 + i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    random_traffic(250, 1'b1);

    // Reset mid-operation with pop held: outputs clear without a clock edge.
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h61 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values();
    check("sb_drained_before_reset", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; pop = 1'b0;
    model_clear();
    // First cycle after release pushes with mode=1: LIFO must still apply.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h21 + i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // ---------------- DEPTH=5 instance, FIFO ----------------
    sel = 1'b1;
    do_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // FIFO full with simultaneous push+pop: head out, tail in.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'hD0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    random_traffic(150, 1'b0);
    random_traffic(150, 1'b1);

    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("sb_final_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/stack_queue_buffer.md
# stack_queue_buffer

Parameterised single-clock storage buffer that operates as a LIFO (stack) or FIFO (queue), selected at run time. It is the successor to the team's fixed-behaviour stack. It adds level-sensitive push/pop with exactly one operation per accepted cycle, simultaneous push+pop, an occupancy count, an almost-full threshold and a registered read-data valid strobe. It sits between a producer and a consumer in the datapath and presents full/empty back-pressure to both.

## Interface
- DATA_W, default 8: data width in bits, ≥1.
- DEPTH, default 8: number of entries, ≥2, any integer (not restricted to powers of two).
- AF_LEVEL, default DEPTH-1: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserting it clears state immediately, deassertion is synchronous to clk.
- mode  in  1  0 = LIFO, 1 = FIFO; captured only while empty (see Operation).
- push  in  1  write request, level-sensitive; one entry per cycle while high and accepted.
- push_data  in  DATA_W  data written on an accepted push.
- pop  in  1  read request, level-sensitive; one entry per cycle while high and accepted.
- pop_data  out  DATA_W  registered read data; holds its value between pops.
- pop_valid  out  1  one-cycle pulse, high the cycle after an accepted pop.
- count  out  $clog2(DEPTH+1)  registered occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- overflow  out  1  sticky error flag (see Configuration).
- underflow  out  1  sticky error flag (see Configuration).
- err_clr  in  1  synchronous clear for overflow/underflow.

## Operation
- Reset values:
  - Outputs: pop_data=0, pop_valid=0, count=0, full=0, empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), overflow=0, underflow=0.
  - Internal state: mode_q=0 (LIFO), pointers=0.
  - Storage array is not reset.
- Effective mode is mode_q. While count==0 and push==0, mode_q ← mode and all pointers return to 0. A push in the same cycle uses the old mode_q.
- Accept rules:
  - push_acc = push & (!full | pop_acc).
  - pop_acc = pop & !empty.
- LIFO mode:
  - Push writes mem[sp] and sp increments.
  - Pop reads mem[sp-1] into pop_data and sp decrements.
  - Push+pop together (non-empty): pop_data ← mem[sp-1], mem[sp-1] ← push_data, sp and count unchanged. This is legal when full.
- FIFO mode:
  - Push writes mem[wr_ptr].
  - Pop reads mem[rd_ptr].
  - Both pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
  - Push+pop together (non-empty): both pointers advance, count unchanged. This is legal when full.
- Push+pop while empty: push accepted, pop rejected, count becomes 1.
- Rejected requests have no effect on storage, pointers, count or pop_data.
- Count update: +1 on push_acc only, −1 on pop_acc only, unchanged on both or neither. Count never leaves 0..DEPTH.

## Timing
- Accepted push: count, full, empty and almost_full reflect the new state from the next rising edge (one-cycle latency). No flag lags count by an extra cycle.
- Accepted pop at edge N: pop_data and pop_valid are valid after edge N; pop_valid deasserts after edge N+1 unless another pop is accepted.
- Push followed by pop of the same entry: minimum two cycles apart, i.e. push at edge N, pop at edge N+1. There is no write-to-read bypass within one cycle.
- Holding push or pop high for K cycles performs K operations, limited by full/empty.
- Reset asserted mid-operation: all outputs take their reset values immediately, without waiting for clk. Any in-flight pop_valid is lost.

## Configuration
- Macro SQB_ERR_FLAGS_EN.
- Defined:
  - overflow sets on push & !push_acc.
  - underflow sets on pop & !pop_acc.
  - Both are sticky until err_clr or reset. err_clr has priority over a new set in the same cycle.
- Undefined:
  - overflow and underflow ports remain present and are tied to 0.
  - err_clr is ignored.
  - No flag logic is synthesised.

## Structure
- Package sqb_pkg:
  - typedef enum logic {MODE_LIFO=1'b0, MODE_FIFO=1'b1} sqb_mode_e.
  - Pointer-wrap helper function next_ptr(ptr, depth).
- Sub-module sqb_occupancy_counter:
  - Inputs: inc, dec (the accept strobes).
  - Outputs: registered count, full, empty, almost_full.
  - Parameters: DEPTH, AF_LEVEL; same clk/reset.
- Top level holds the storage array, pointers/sp, mode_q, the read register and the error flags.

## Test plan
- LIFO, DEPTH=8: push 0x11..0x18 over 8 cycles → full=1, count=8. A 9th push is rejected (overflow=1 with SQB_ERR_FLAGS_EN). Pop ×8 returns 0x18..0x11, each with pop_valid, ending empty=1.
- FIFO, DEPTH=5 (non-power-of-two): push 0xA0..0xA4, pop 3, push 0xB0..0xB2 → pops return 0xA3,0xA4,0xB0,0xB1,0xB2. Verifies wrap.
- Full, simultaneous push+pop: in LIFO, top 0x18 is returned, 0x55 replaces it, count stays 8. In FIFO, head is returned, tail is written, count stays 5.
- Mode capture: set mode=1 while count=3 → behaviour stays LIFO. Drain to empty, hold push low one cycle → subsequent traffic is FIFO order.
- AF_LEVEL=6, DEPTH=8: almost_full rises the cycle count becomes 6 and falls when count drops to 5. Pop while empty → pop_valid stays 0, pop_data unchanged, underflow=1. err_clr clears it.
- Assert reset with count=4 and pop held high → outputs go to reset values immediately. After release, empty=1 and mode_q=LIFO.
